// File: rtl/log_pkg.sv
// Shared helpers for the log-domain converter: width derivation and
// packing of the {exponent, fraction} log word.
package log_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Signed exponent must span pos - QP for any pos in 0..WIDTH-1 plus a round carry.
  function automatic int exp_width(input int width);
    return clog2(width) + 2;
  endfunction

  function automatic logic [63:0] pack_log(input logic [31:0] exp_val,
                                           input logic [31:0] frac_val,
                                           input int          frac_w);
    return ({32'b0, exp_val} << frac_w) | {32'b0, frac_val};
  endfunction

endpackage

// File: rtl/lod_param.sv
// Parametrised leading-one detector: position of the highest set bit and a
// non-zero flag.
module lod_param
  import log_pkg::*;
#(
  parameter int  WIDTH = 16,
  localparam int POS_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [POS_W-1:0] pos,
  output logic             nz
);

  // NOTE: pos gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) pos = POS_W'(i);
    end
  end

  assign nz = |data;

endmodule

// File: rtl/log_conv_pipe.sv
// Three-stage signed fixed-point to sign + log-domain converter with a
// valid/ready stream and a single global stall.
module log_conv_pipe
  import log_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  QP     = 12,
  parameter int  FRAC_W = 12,
  parameter int  ROUND  = 0,
  localparam int EXP_W  = exp_width(WIDTH),
  localparam int LOG_W  = EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG_W-1:0] out_log,
  output logic             out_sign,
  output logic             out_nz,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int POS_W = clog2(WIDTH);
  localparam int EXT_W = WIDTH + FRAC_W;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: sign and magnitude; the most-negative input maps to 2^(WIDTH-1) unsigned.
  logic             v1, sign1;
  logic [WIDTH-1:0] abs1;

  // NOTE: all pipeline state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      abs1  <= '0;
    end else if (adv) begin
      v1    <= in_valid;
      sign1 <= in_data[WIDTH-1];
      abs1  <= in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
    end
  end

  // S2: normalise so the leading one sits at the MSB; only the bits below it are kept.
  logic [POS_W-1:0] lod_pos;
  logic             lod_nz;
  logic [POS_W-1:0] shamt;

  lod_param #(.WIDTH(WIDTH)) u_lod (
    .data (abs1),
    .pos  (lod_pos),
    .nz   (lod_nz)
  );

  assign shamt = POS_W'(WIDTH - 1) - lod_pos;

  logic             v2, sign2, nz2;
  logic [POS_W-1:0] pos2;
  logic [WIDTH-2:0] norm2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      nz2   <= 1'b0;
      pos2  <= '0;
      norm2 <= '0;
    end else if (adv) begin
      v2    <= v1;
      sign2 <= sign1;
      nz2   <= lod_nz;
      pos2  <= lod_pos;
      norm2 <= (WIDTH-1)'(abs1 << shamt);
    end
  end

  // S3: fraction is the top FRAC_W bits below the leading one, zero-padded when short.
  logic [EXT_W-1:0]  ext;
  logic [FRAC_W-1:0] frac_t, frac_d;
  logic              rbit;
  logic [EXP_W-1:0]  exp_raw, exp_d;

  assign ext     = {norm2, {(FRAC_W + 1){1'b0}}};
  assign frac_t  = FRAC_W'(ext >> (EXT_W - FRAC_W));
  assign rbit    = ext[EXT_W-1-FRAC_W];
  assign exp_raw = {{(EXP_W - POS_W){1'b0}}, pos2} - EXP_W'(QP);

  always_comb begin
    frac_d = frac_t;
    exp_d  = exp_raw;
    if (ROUND != 0 && rbit) begin
      if (&frac_t) begin
        frac_d = '0;
        exp_d  = exp_raw + EXP_W'(1);
      end else begin
        frac_d = frac_t + FRAC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_log   <= '0;
      out_sign  <= 1'b0;
      out_nz    <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      out_nz    <= nz2;
      out_sign  <= nz2 & sign2;
      out_log   <= nz2 ? LOG_W'(pack_log(32'(exp_d), 32'(frac_d), FRAC_W)) : '0;
    end
  end

endmodule

// File: doc/log_conv_pipe.md
Name: log_conv_pipe

Overview:
- Pipelined, parametrised successor of the combinational 16-bit log converter.
- Converts a signed fixed-point sample (QP fractional bits) into sign plus log-domain word {exponent, fraction}, where exponent = leading-one position − QP.
- Adds a valid/ready stream with full backpressure, optional round-to-nearest on the fraction, and explicit zero/overflow handling.
- Sits between the input sample path and the log-domain weight-update multipliers of the FLAF datapath.

Parameters:
- WIDTH, 16, input sample width (two's complement).
- QP, 12, fractional bits of the input sample.
- FRAC_W, 12, log fraction width.
- ROUND, 0, 0 = truncate fraction; 1 = round-half-up with carry into exponent.
- EXP_W, $clog2(WIDTH)+2, signed exponent width (localparam, derived).
- LOG_W, EXP_W+FRAC_W, log word width (localparam, derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  signed input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  pipeline can accept a sample this cycle.
- out_log  out  LOG_W  {signed exponent EXP_W, fraction FRAC_W}; Q(EXP_W).(FRAC_W).
- out_sign  out  1  sign of the input sample.
- out_nz  out  1  1 = input non-zero (log valid); 0 = input was zero.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Reset clears all stage valids and all output registers to 0: out_valid=0, out_log=0, out_sign=0, out_nz=0.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv (combinational).
  - A transfer occurs when in_valid && in_ready.
  - When adv=0, all stages hold (global stall); no bubble collapse.
  - out_* stay stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid with no stall. Throughput: 1 sample/cycle.
- S1: register sign = in_data[WIDTH-1], abs = sign ? −in_data : in_data, taken as WIDTH-bit unsigned. Most-negative input gives abs = 2^(WIDTH-1), which is correct as unsigned.
- S2:
  - Leading-one detect gives pos (0..WIDTH-1) and nz = |abs.
  - Register norm = abs << (WIDTH-1-pos), which puts the leading one at the MSB.
- S3:
  - frac = norm[WIDTH-2 -: FRAC_W]. If FRAC_W > WIDTH-1, zero-pad the LSBs.
  - exp = pos − QP, sign-extended to EXP_W.
  - ROUND=1: add the bit just below the frac LSB (0 if none). If frac overflows, set frac=0 and exp=exp+1.
  - nz=0 forces out_log=0 and out_sign=0.
  - Register out_log, out_sign, out_nz.
- Mid-operation reset: every in-flight sample is discarded. The first output after reset release is the first sample accepted after release.
- Simultaneous in_valid and stalled output: the sample is not accepted (in_ready=0). The upstream must hold in_valid and in_data.

Decomposition:
- Package log_pkg: function clog2, EXP_W/LOG_W derivation, function to pack {exp, frac}.
- Sub-module lod_param (parametrised leading-one detector: data → pos, nz), used in S2. It is the generalised replacement for the fixed 16-bit detector.

Test Plan:
All cases use WIDTH=16, QP=12, FRAC_W=12, EXP_W=6, ROUND=0 unless stated.
- 0x1000 (1.0) → out_log=0x00000, sign=0, nz=1, out_valid exactly 3 cycles after acceptance.
- 0x1800 (1.5) → 0x00800. 0xD000 (−3.0) → 0x01800, sign=1. 0x0001 → 0x34000 (exp −12).
- 0x0000 → out_log=0, nz=0, sign=0. 0x8000 (−8.0) → 0x03000, sign=1.
- 0x7FFF: ROUND=0 → 0x02FFF; ROUND=1 → 0x03000 (fraction carry into exponent).
- Back-to-back stream of 8 samples with out_ready low for 5 cycles mid-stream → in_ready drops the same cycle, no loss or duplication, order preserved, outputs stable during stall.
- rst_n asserted with 3 samples in flight → out_valid=0 immediately (asynchronous), none of those samples appear after release.
